// File: rtl/vga_fb_arbiter.sv
// Shares the single-port frame-buffer SRAM between the VGA raster reader (absolute priority)
// and the convolution result writer; pixels reach the driver 2 cycles after vga_ready.
module vga_fb_arbiter #(
  parameter int H_PIX  = 640,
  parameter int V_PIX  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_ready,
  input  logic              vga_vsync,
  output logic [DATA_W-1:0] pixel,
  output logic              frame_start,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_overrun,
  output logic              wr_oob
);

  localparam int              TOTAL   = H_PIX * V_PIX;
  localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(TOTAL - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_pend_q;
  logic [DATA_W-1:0]   pixel_q, pixel_d;
  logic                frame_start_q, frame_start_d;
  logic                rd_overrun_q, rd_overrun_d;
  logic                wr_oob_q, wr_oob_d;
  logic                vsync_q;
  logic                wrapped_q, wrapped_d;

  logic fall, rd_en, wr_acc, wr_inrange;

  always_comb begin
    fall       = vsync_q && !vga_vsync;
    rd_en      = (state_q == RUN) && vga_ready;
    wr_ready   = !rd_en;
    wr_acc     = wr_valid && !rd_en;
    wr_inrange = {1'b0, wr_addr} < TOTAL_W;
    mem_addr   = rd_en ? rd_addr_q : wr_addr;
    mem_we     = wr_acc && wr_inrange;
    mem_wdata  = wr_data;
    pixel_d    = rd_pend_q ? mem_rdata : '0;
  end

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wrapped_d     = wrapped_q;
    frame_start_d = 1'b0;
    rd_overrun_d  = rd_overrun_q;
    wr_oob_d      = wr_oob_q | (wr_acc & !wr_inrange);
    if (state_q == SYNC) begin
      if (fall) begin
        state_d   = RUN;
        rd_addr_d = '0;
        wrapped_d = 1'b0;
      end
    end else begin
      if (rd_en) begin
        // wrapped_q marks a frame fully read with no new vsync yet
        if (wrapped_q && rd_addr_q == '0) rd_overrun_d = 1'b1;
        if (rd_addr_q == LAST) begin
          rd_addr_d = '0;
          wrapped_d = 1'b1;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      if (fall) begin
        rd_addr_d     = '0;
        wrapped_d     = 1'b0;
        frame_start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SYNC;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      pixel_q       <= '0;
      frame_start_q <= 1'b0;
      rd_overrun_q  <= 1'b0;
      wr_oob_q      <= 1'b0;
      vsync_q       <= 1'b1;
      wrapped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      rd_pend_q     <= rd_en;
      pixel_q       <= pixel_d;
      frame_start_q <= frame_start_d;
      rd_overrun_q  <= rd_overrun_d;
      wr_oob_q      <= wr_oob_d;
      vsync_q       <= vga_vsync;
      wrapped_q     <= wrapped_d;
    end
  end

  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;
  assign rd_overrun  = rd_overrun_q;
  assign wr_oob      = wr_oob_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a 4x2 frame with an SRAM model preloaded to 0x100+i.
module tb_vga_fb_arbiter;

  localparam int AW = 4;
  localparam int DW = 12;

  logic          clk, rst, vga_ready, vga_vsync;
  logic [DW-1:0] pixel;
  logic          frame_start;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          rd_overrun, wr_oob;

  logic [DW-1:0] mem [16];
  int checks = 0;
  int errors = 0;

  vga_fb_arbiter #(.H_PIX(4), .V_PIX(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .vga_ready(vga_ready), .vga_vsync(vga_vsync),
    .pixel(pixel), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_overrun(rd_overrun), .wr_oob(wr_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with 1-cycle read latency
  initial for (int i = 0; i < 16; i++) mem[i] <= DW'(12'h100 + i);
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vga_ready = 1'b0; vga_vsync = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    #3;
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_overrun", 32'(rd_overrun), 32'h0);
    check("rst_oob", 32'(wr_oob), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // First vsync edge: leave SYNC without a frame_start pulse
    vga_vsync = 1'b0; tick();
    check("first_edge_no_fs", 32'(frame_start), 32'h0);
    vga_vsync = 1'b1;
    for (int j = 0; j < 10; j++) begin
      vga_ready = (j < 8);
      #1;
      if (j < 8) begin
        check("f1_mem_addr", 32'(mem_addr), 32'(j));
        check("f1_wr_ready", 32'(wr_ready), 32'h0);
      end
      check("f1_pixel", 32'(pixel), (j < 2) ? 32'h0 : 32'h100 + 32'(j - 2));
      tick();
    end
    vga_ready = 1'b0;
    check("f1_no_overrun", 32'(rd_overrun), 32'h0);

    // Second frame: frame_start pulse, 9 reads overrun
    vga_vsync = 1'b0; tick();
    check("f2_fs_high", 32'(frame_start), 32'h1);
    vga_vsync = 1'b1; tick();
    check("f2_fs_low", 32'(frame_start), 32'h0);
    for (int j = 0; j < 9; j++) begin
      vga_ready = 1'b1;
      #1;
      check("f2_mem_addr", 32'(mem_addr), 32'(j % 8));
      if (j == 8) check("f2_overrun_pre", 32'(rd_overrun), 32'h0);
      tick();
    end
    vga_ready = 1'b0;
    check("f2_overrun", 32'(rd_overrun), 32'h1);
    vga_vsync = 1'b0; tick();
    check("f3_fs_high", 32'(frame_start), 32'h1);
    vga_vsync = 1'b1; tick();
    check("overrun_sticky", 32'(rd_overrun), 32'h1);

    // Reader beats a held write request
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 12'hABC;
    for (int j = 0; j < 2; j++) begin
      vga_ready = 1'b1;
      #1;
      check("conf_wr_ready", 32'(wr_ready), 32'h0);
      check("conf_mem_we", 32'(mem_we), 32'h0);
      check("conf_mem_addr", 32'(mem_addr), 32'(j));
      tick();
    end
    vga_ready = 1'b0;
    #1;
    check("wr_ready", 32'(wr_ready), 32'h1);
    check("wr_mem_we", 32'(mem_we), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h3);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hABC);
    tick();
    wr_valid = 1'b0;
    vga_ready = 1'b1; tick();            // reads addr 2
    vga_ready = 1'b1; #1;
    check("rb_mem_addr", 32'(mem_addr), 32'h3);
    tick();
    vga_ready = 1'b0;
    check("rb_pixel2", 32'(pixel), 32'h102);
    tick();
    check("rb_pixel3", 32'(pixel), 32'hABC);

    // Read addr 4 so rd_addr sits at 5 with a live pixel
    vga_ready = 1'b1; tick();
    vga_ready = 1'b0; tick();
    check("pre_rst_pixel", 32'(pixel), 32'h104);

    // Asynchronous reset mid-frame
    rst = 1'b1; #1;
    check("arst_pixel", 32'(pixel), 32'h0);
    check("arst_overrun", 32'(rd_overrun), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);
    tick();
    rst = 1'b0; tick();
    vga_ready = 1'b1; #1;
    check("sync_no_read", 32'(wr_ready), 32'h1);
    tick(); tick();
    check("sync_pixel", 32'(pixel), 32'h0);
    vga_ready = 1'b0;

    // Out-of-range write while in SYNC
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 12'h555;
    #1;
    check("oob_wr_ready", 32'(wr_ready), 32'h1);
    check("oob_mem_we", 32'(mem_we), 32'h0);
    check("oob_pre", 32'(wr_oob), 32'h0);
    tick();
    wr_valid = 1'b0;
    check("oob_flag", 32'(wr_oob), 32'h1);

    // Reads restart at 0 after the next edge; edge coincident with a read at 6
    vga_vsync = 1'b0; tick();
    check("rst_edge_no_fs", 32'(frame_start), 32'h0);
    vga_vsync = 1'b1;
    for (int j = 0; j < 6; j++) begin
      vga_ready = 1'b1;
      #1;
      check("restart_addr", 32'(mem_addr), 32'(j));
      tick();
    end
    vga_ready = 1'b1; vga_vsync = 1'b0;
    #1;
    check("coinc_addr6", 32'(mem_addr), 32'h6);
    tick();
    vga_vsync = 1'b1;
    check("coinc_fs", 32'(frame_start), 32'h1);
    #1;
    check("coinc_next_addr", 32'(mem_addr), 32'h0);
    tick();
    vga_ready = 1'b0;
    check("coinc_no_overrun", 32'(rd_overrun), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
